// File: rtl/adder_cla_pipe.sv
// adder_cla_pipe: pipelined carry-lookahead add/subtract, one CLA segment per stage, valid/ready flow control
module adder_cla_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ov,
    output logic             out_zero
);
    localparam int SEG = WIDTH / STAGES;

    // Returns carries c[0..SEG] of one segment using a parallel-prefix lookahead
    function automatic logic [SEG:0] cla_carry(input logic [SEG-1:0] a, input logic [SEG-1:0] b, input logic cin);
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG:0]   c;
        g = a & b;
        p = a ^ b;
        for (int d = 1; d < SEG; d = d * 2)
            for (int i = SEG - 1; i >= d; i--) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        c[0] = cin;
        for (int i = 0; i < SEG; i++)
            c[i+1] = g[i] | (p[i] & cin);
        return c;
    endfunction

    logic             advance;
    logic             v_in   [STAGES];
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] s_in   [STAGES];
    logic             sub_in [STAGES];
    logic             sgn_in [STAGES];
    logic             c_in   [STAGES];

    // Global stall: every stage moves only when the output slot frees up
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;
    assign v_in[0]   = in_valid;
    assign a_in[0]   = in_a;
    assign b_in[0]   = in_b;
    assign s_in[0]   = '0;
    assign sub_in[0] = in_sub;
    assign sgn_in[0] = in_signed;
    assign c_in[0]   = in_sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0]   a_seg;
        logic [SEG-1:0]   b_seg;
        logic [SEG-1:0]   s_seg;
        logic [SEG:0]     c;
        logic [WIDTH-1:0] s_all;
        assign a_seg = a_in[k][k*SEG +: SEG];
        assign b_seg = b_in[k][k*SEG +: SEG] ^ {SEG{sub_in[k]}};
        assign c     = cla_carry(a_seg, b_seg, c_in[k]);
        assign s_seg = a_seg ^ b_seg ^ c[SEG-1:0];
        always_comb begin
            s_all = s_in[k];
            s_all[k*SEG +: SEG] = s_seg;
        end
        if (k < STAGES - 1) begin : g_skew
            logic             v_q;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] s_q;
            logic             sub_q;
            logic             sgn_q;
            logic             c_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q   <= 1'b0;
                    a_q   <= '0;
                    b_q   <= '0;
                    s_q   <= '0;
                    sub_q <= 1'b0;
                    sgn_q <= 1'b0;
                    c_q   <= 1'b0;
                end else if (advance) begin
                    v_q   <= v_in[k];
                    a_q   <= a_in[k];
                    b_q   <= b_in[k];
                    s_q   <= s_all;
                    sub_q <= sub_in[k];
                    sgn_q <= sgn_in[k];
                    c_q   <= c[SEG];
                end
            end
            assign v_in[k+1]   = v_q;
            assign a_in[k+1]   = a_q;
            assign b_in[k+1]   = b_q;
            assign s_in[k+1]   = s_q;
            assign sub_in[k+1] = sub_q;
            assign sgn_in[k+1] = sgn_q;
            assign c_in[k+1]   = c_q;
        end else begin : g_out
            // c[SEG] is the carry out of bit WIDTH-1, c[SEG-1] the carry into it
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    out_sum   <= '0;
                    out_cout  <= 1'b0;
                    out_ov    <= 1'b0;
                    out_zero  <= 1'b0;
                end else if (advance) begin
                    out_valid <= v_in[k];
                    if (v_in[k]) begin
                        out_sum  <= s_all;
                        out_cout <= c[SEG];
                        out_ov   <= sgn_in[k] ? (c[SEG] ^ c[SEG-1]) : (c[SEG] ^ sub_in[k]);
                        out_zero <= (s_all == '0);
                    end
                end
            end
        end
    end
endmodule
